// File: rtl/execute.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution, and the EX/MEM pipeline register feeding the memory stage.
module execute #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regwriteE,
  input  logic            memrwE,
  input  logic            brunE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic            jalrE,
  input  logic            bselE,
  input  logic [1:0]      aselE,
  input  logic [1:0]      wbselE,
  input  logic [3:0]      ALUselE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      rdE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] imm_exE,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] pc4E,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  output logic            pcsrcE,
  output logic [XLEN-1:0] pctargetE,
  output logic            misalignE,
  output logic            regwriteM,
  output logic            memrwM,
  output logic [1:0]      wbselM,
  output logic [2:0]      funct3M,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM,
  output logic [XLEN-1:0] pc4M
);

  logic [XLEN-1:0] src_a, src_b, alu_a, alu_b, alu_y;
  logic            eq, lt, taken;

  logic            regwrite_d, regwrite_q;
  logic            memrw_d, memrw_q;
  logic [1:0]      wbsel_d, wbsel_q;
  logic [2:0]      funct3_d, funct3_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] aluresult_d, aluresult_q;
  logic [XLEN-1:0] writedata_d, writedata_q;
  logic [XLEN-1:0] pc4_d, pc4_q;

  // Forwarding from aluresultM reads the registered value, i.e. the older result.
  always_comb begin
    case (forwardAE)
      2'b01:   src_a = resultW;
      2'b10:   src_a = aluresultM;
      default: src_a = rd1E;
    endcase
    case (forwardBE)
      2'b01:   src_b = resultW;
      2'b10:   src_b = aluresultM;
      default: src_b = rd2E;
    endcase
    case (aselE)
      2'b01:   alu_a = pcE;
      2'b10:   alu_a = '0;
      default: alu_a = src_a;
    endcase
    alu_b = bselE ? imm_exE : src_b;
  end

  always_comb begin
    case (ALUselE)
      4'b0000: alu_y = alu_a + alu_b;
      4'b0001: alu_y = alu_a - alu_b;
      4'b0010: alu_y = alu_a & alu_b;
      4'b0011: alu_y = alu_a | alu_b;
      4'b0100: alu_y = alu_a ^ alu_b;
      4'b0101: alu_y = alu_a << alu_b[4:0];
      4'b0110: alu_y = alu_a >> alu_b[4:0];
      4'b0111: alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1000: alu_y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      4'b1001: alu_y = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    eq = (src_a == src_b);
    lt = brunE ? (src_a < src_b) : ($signed(src_a) < $signed(src_b));
    case (funct3E)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = lt;
      3'b111:  taken = ~lt;
      default: taken = 1'b0;
    endcase
    pcsrcE    = jumpE | (branchE & taken);
    pctargetE = jalrE ? ((src_a + imm_exE) & ~XLEN'(1)) : (pcE + imm_exE);
    misalignE = pcsrcE & (pctargetE[1:0] != 2'b00);
  end

  always_comb begin
    regwrite_d  = regwriteE;
    memrw_d     = memrwE;
    wbsel_d     = wbselE;
    funct3_d    = funct3E;
    rd_d        = rdE;
    aluresult_d = alu_y;
    writedata_d = src_b;
    pc4_d       = pc4E;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q  <= 1'b0;
      memrw_q     <= 1'b0;
      wbsel_q     <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      aluresult_q <= '0;
      writedata_q <= '0;
      pc4_q       <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memrw_q     <= memrw_d;
      wbsel_q     <= wbsel_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      pc4_q       <= pc4_d;
    end
  end

  assign regwriteM  = regwrite_q;
  assign memrwM     = memrw_q;
  assign wbselM     = wbsel_q;
  assign funct3M    = funct3_q;
  assign rdM        = rd_q;
  assign aluresultM = aluresult_q;
  assign writedataM = writedata_q;
  assign pc4M       = pc4_q;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed corner cases plus randomized
// stimulus against a behavioural model of the EX stage.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteE, memrwE, brunE, branchE, jumpE, jalrE, bselE;
  logic [1:0]  aselE, wbselE, forwardAE, forwardBE;
  logic [3:0]  ALUselE;
  logic [2:0]  funct3E;
  logic [4:0]  rdE;
  logic [31:0] rd1E, rd2E, imm_exE, pcE, pc4E, resultW;
  logic        pcsrcE, misalignE, regwriteM, memrwM;
  logic [31:0] pctargetE, aluresultM, writedataM, pc4M;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;

  int checkCount = 0;
  int passCount  = 0;

  // Model copy of the EX/MEM register contents.
  logic        expRegwrite, expMemrw;
  logic [1:0]  expWbsel;
  logic [2:0]  expFunct3;
  logic [4:0]  expRd;
  logic [31:0] expAlu, expWdata, expPc4;

  execute dut (
    .clk(clk), .rst_n(rst_n),
    .regwriteE(regwriteE), .memrwE(memrwE), .brunE(brunE), .branchE(branchE),
    .jumpE(jumpE), .jalrE(jalrE), .bselE(bselE), .aselE(aselE), .wbselE(wbselE),
    .ALUselE(ALUselE), .funct3E(funct3E), .rdE(rdE), .rd1E(rd1E), .rd2E(rd2E),
    .imm_exE(imm_exE), .pcE(pcE), .pc4E(pc4E), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .resultW(resultW), .pcsrcE(pcsrcE),
    .pctargetE(pctargetE), .misalignE(misalignE), .regwriteM(regwriteM),
    .memrwM(memrwM), .wbselM(wbselM), .funct3M(funct3M), .rdM(rdM),
    .aluresultM(aluresultM), .writedataM(writedataM), .pc4M(pc4M)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    else
      passCount++;
  endtask

  function automatic logic [31:0] pickSrc(input logic [1:0] fwd, input logic [31:0] rf);
    if (fwd == 2'b01) return resultW;
    if (fwd == 2'b10) return expAlu;
    return rf;
  endfunction

  function automatic logic [31:0] modelAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b[4:0]);
    case (op)
      4'd0: return 32'(ua + ub);
      4'd1: return 32'(ua - ub);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return 32'(ua * (64'd1 << sh));
      4'd6: return 32'(ua / (64'd1 << sh));
      4'd7: return 32'(sa >>> sh);
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelTaken(input logic [2:0] f3, input logic uns, input logic [31:0] a, input logic [31:0] b);
    longint va, vb;
    va = uns ? longint'(a) : longint'($signed(a));
    vb = uns ? longint'(b) : longint'($signed(b));
    case (f3)
      3'b000: return va == vb;
      3'b001: return va != vb;
      3'b100, 3'b110: return va < vb;
      3'b101, 3'b111: return va >= vb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clearModel();
    expRegwrite = 0; expMemrw = 0; expWbsel = 0; expFunct3 = 0;
    expRd = 0; expAlu = 0; expWdata = 0; expPc4 = 0;
  endtask

  task automatic checkMOutputs(input string pfx);
    checkOutput({pfx, "_regwriteM"},  32'(regwriteM),  32'(expRegwrite));
    checkOutput({pfx, "_memrwM"},     32'(memrwM),     32'(expMemrw));
    checkOutput({pfx, "_wbselM"},     32'(wbselM),     32'(expWbsel));
    checkOutput({pfx, "_funct3M"},    32'(funct3M),    32'(expFunct3));
    checkOutput({pfx, "_rdM"},        32'(rdM),        32'(expRd));
    checkOutput({pfx, "_aluresultM"}, aluresultM,      expAlu);
    checkOutput({pfx, "_writedataM"}, writedataM,      expWdata);
    checkOutput({pfx, "_pc4M"},       pc4M,            expPc4);
  endtask

  // Inputs are already driven (clock low); checks combinational outputs, takes one edge, checks the register.
  task automatic applyStimulus(input string tag);
    logic [31:0] a, b, opA, opB, tgt;
    logic        redirect;
    #1;
    a   = pickSrc(forwardAE, rd1E);
    b   = pickSrc(forwardBE, rd2E);
    opA = (aselE == 2'b01) ? pcE : (aselE == 2'b10) ? 32'd0 : a;
    opB = bselE ? imm_exE : b;
    redirect = jumpE || (branchE && modelTaken(funct3E, brunE, a, b));
    tgt = jalrE ? ((a + imm_exE) & 32'hFFFF_FFFE) : (pcE + imm_exE);
    checkOutput({tag, "_pcsrcE"},    32'(pcsrcE),    32'(redirect));
    checkOutput({tag, "_pctargetE"}, pctargetE,      tgt);
    checkOutput({tag, "_misalignE"}, 32'(misalignE), 32'(redirect && (tgt % 4 != 0)));
    @(posedge clk);
    if (rst_n) begin
      expRegwrite = regwriteE; expMemrw = memrwE; expWbsel = wbselE;
      expFunct3 = funct3E; expRd = rdE; expAlu = modelAlu(ALUselE, opA, opB);
      expWdata = b; expPc4 = pc4E;
    end else begin
      clearModel();
    end
    @(negedge clk);
    checkMOutputs(tag);
  endtask

  task automatic idleInputs();
    regwriteE = 0; memrwE = 0; brunE = 0; branchE = 0; jumpE = 0; jalrE = 0;
    bselE = 0; aselE = 0; wbselE = 0; ALUselE = 0; funct3E = 0; rdE = 0;
    rd1E = 0; rd2E = 0; imm_exE = 0; pcE = 0; pc4E = 0;
    forwardAE = 0; forwardBE = 0; resultW = 0;
  endtask

  task automatic aluOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    idleInputs();
    ALUselE = op; rd1E = a; rd2E = b; regwriteE = 1; rdE = 5'd4;
    applyStimulus(tag);
  endtask

  task automatic randomInputs();
    {regwriteE, memrwE, brunE, branchE, jumpE, jalrE, bselE} = 7'($urandom);
    aselE = 2'($urandom); wbselE = 2'($urandom); ALUselE = 4'($urandom);
    funct3E = 3'($urandom); rdE = 5'($urandom);
    rd1E = $urandom; rd2E = ($urandom_range(0, 3) == 0) ? rd1E : $urandom;
    imm_exE = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
    pcE = $urandom & 32'hFFFF_FFFC; pc4E = pcE + 32'd4;
    forwardAE = 2'($urandom); forwardBE = 2'($urandom); resultW = $urandom;
  endtask

  initial begin
    idleInputs();
    clearModel();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkMOutputs("reset");
    rst_n = 1'b1;

    // Plain add
    idleInputs();
    rd1E = 32'd7; rd2E = 32'd5; rdE = 5'd3; regwriteE = 1;
    applyStimulus("t1");
    checkOutput("t1_add_alu", aluresultM, 32'd12);
    checkOutput("t1_add_rd", 32'(rdM), 32'd3);
    checkOutput("t1_add_regwrite", 32'(regwriteM), 32'd1);

    // ALU corner cases
    aluOp(4'b0001, 32'd0, 32'd1, "t2_sub");
    checkOutput("t2_sub_val", aluresultM, 32'hFFFF_FFFF);
    aluOp(4'b0111, 32'h8000_0000, 32'd31, "t2_sra");
    checkOutput("t2_sra_val", aluresultM, 32'hFFFF_FFFF);
    aluOp(4'b1001, 32'd1, 32'hFFFF_FFFF, "t2_sltu");
    checkOutput("t2_sltu_val", aluresultM, 32'd1);
    aluOp(4'b1000, 32'd1, 32'hFFFF_FFFF, "t2_slt");
    checkOutput("t2_slt_val", aluresultM, 32'd0);
    aluOp(4'b1100, 32'd3, 32'd4, "t2_undef");
    checkOutput("t2_undef_val", aluresultM, 32'd0);

    // addi x1,x0,5 then add x2,x1,x1 forwarded from aluresultM, then from resultW
    idleInputs();
    imm_exE = 32'd5; bselE = 1; regwriteE = 1; rdE = 5'd1;
    applyStimulus("t3_addi");
    idleInputs();
    forwardAE = 2'b10; forwardBE = 2'b10; regwriteE = 1; rdE = 5'd2;
    applyStimulus("t3_fwdM");
    checkOutput("t3_fwdM_val", aluresultM, 32'd10);
    idleInputs();
    forwardAE = 2'b01; forwardBE = 2'b01; resultW = 32'd9; regwriteE = 1; rdE = 5'd2;
    applyStimulus("t3_fwdW");
    checkOutput("t3_fwdW_val", aluresultM, 32'd18);

    // Branches
    idleInputs();
    branchE = 1; brunE = 1; funct3E = 3'b110; rd1E = 32'd1; rd2E = 32'hFFFF_FFFF;
    #1 checkOutput("t4_bltu_taken", 32'(pcsrcE), 32'd1);
    applyStimulus("t4_bltu");
    brunE = 0; funct3E = 3'b100;
    #1 checkOutput("t4_blt_taken", 32'(pcsrcE), 32'd0);
    applyStimulus("t4_blt");
    idleInputs();
    branchE = 1; funct3E = 3'b000; rd1E = 32'd42; rd2E = 32'd42;
    pcE = 32'd100; imm_exE = 32'hFFFF_FFF8;
    #1 checkOutput("t4_beq_target", pctargetE, 32'h0000_005C);
    checkOutput("t4_beq_taken", 32'(pcsrcE), 32'd1);
    applyStimulus("t4_beq");

    // jalr and misaligned jal
    idleInputs();
    jumpE = 1; jalrE = 1; rd1E = 32'h1001; imm_exE = 32'd4; wbselE = 2'b10;
    regwriteE = 1; rdE = 5'd1; pcE = 32'h200; pc4E = 32'h204;
    #1 checkOutput("t5_jalr_target", pctargetE, 32'h1004);
    checkOutput("t5_jalr_pcsrc", 32'(pcsrcE), 32'd1);
    applyStimulus("t5_jalr");
    checkOutput("t5_jalr_wbsel", 32'(wbselM), 32'd2);
    checkOutput("t5_jalr_pc4", pc4M, 32'h204);
    idleInputs();
    jumpE = 1; pcE = 32'h100; imm_exE = 32'd2;
    #1 checkOutput("t5_jal_misalign", 32'(misalignE), 32'd1);
    applyStimulus("t5_jal");

    // Randomized stream
    for (int i = 0; i < 300; i++) begin
      randomInputs();
      applyStimulus("rand");
    end

    // Reset between edges with a store in flight
    idleInputs();
    memrwE = 1; rd2E = 32'hDEAD_BEEF; funct3E = 3'b010; pc4E = 32'h44;
    applyStimulus("t6_store");
    checkOutput("t6_store_captured", 32'(memrwM), 32'd1);
    #2 rst_n = 1'b0;
    #1 clearModel();
    checkMOutputs("t6_async");
    @(posedge clk);
    #1 checkOutput("t6_held_memrw", 32'(memrwM), 32'd0);
    checkOutput("t6_held_wdata", writedataM, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randomInputs();
      applyStimulus("post_reset");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
